// File: rtl/frogger_car_traffic.sv
// Five-lane car position generator: shared prescaler, per-lane step counters,
// wrap-around X motion and a saturating speed level that shortens every lane period.
`timescale 1ns/1ps
module frogger_car_traffic #(
    parameter int unsigned c_GAME_WIDTH = 14,
    parameter int unsigned c_BASE_DIV   = 25000000,
    parameter logic [5:0]  c_LANE_Y_1   = 6'd9,
    parameter logic [5:0]  c_LANE_Y_2   = 6'd8,
    parameter logic [5:0]  c_LANE_Y_3   = 6'd7,
    parameter logic [5:0]  c_LANE_Y_4   = 6'd6,
    parameter logic [5:0]  c_LANE_Y_5   = 6'd5,
    parameter logic [5:0]  c_START_X_1  = 6'd0,
    parameter logic [5:0]  c_START_X_2  = 6'd3,
    parameter logic [5:0]  c_START_X_3  = 6'd6,
    parameter logic [5:0]  c_START_X_4  = 6'd9,
    parameter logic [5:0]  c_START_X_5  = 6'd12,
    parameter logic [3:0]  c_SPEED_1    = 4'd4,
    parameter logic [3:0]  c_SPEED_2    = 4'd3,
    parameter logic [3:0]  c_SPEED_3    = 4'd2,
    parameter logic [3:0]  c_SPEED_4    = 4'd3,
    parameter logic [3:0]  c_SPEED_5    = 4'd1,
    parameter logic [4:0]  c_DIR        = 5'b01010
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Freeze,
    input  logic       i_Speed_Up,
    input  logic       i_Level_Reset,
    output logic [5:0] o_Car_X_1,
    output logic [5:0] o_Car_X_2,
    output logic [5:0] o_Car_X_3,
    output logic [5:0] o_Car_X_4,
    output logic [5:0] o_Car_X_5,
    output logic [5:0] o_Car_Y_1,
    output logic [5:0] o_Car_Y_2,
    output logic [5:0] o_Car_Y_3,
    output logic [5:0] o_Car_Y_4,
    output logic [5:0] o_Car_Y_5,
    output logic [1:0] o_Level,
    output logic       o_Step
);

    localparam int unsigned N_CARS     = 5;
    localparam int unsigned PW         = (c_BASE_DIV > 1) ? $clog2(c_BASE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(c_BASE_DIV - 1);
    localparam logic [5:0] X_LAST      = 6'(c_GAME_WIDTH - 1);

    localparam logic [5:0] LANE_Y  [N_CARS] = '{c_LANE_Y_1, c_LANE_Y_2, c_LANE_Y_3, c_LANE_Y_4, c_LANE_Y_5};
    localparam logic [5:0] START_X [N_CARS] = '{c_START_X_1, c_START_X_2, c_START_X_3, c_START_X_4, c_START_X_5};
    localparam logic [3:0] SPEED   [N_CARS] = '{c_SPEED_1, c_SPEED_2, c_SPEED_3, c_SPEED_4, c_SPEED_5};

    logic [PW-1:0]     presc;
    logic              tick;
    logic [1:0]        level;
    logic              step;
    logic [5:0]        car_x    [N_CARS];
    logic [5:0]        car_y    [N_CARS];
    logic [3:0]        lane_cnt [N_CARS];
    logic [N_CARS-1:0] move;

    function automatic logic [3:0] eff_period(input logic [3:0] speed, input logic [1:0] lvl);
        logic [3:0] p;
        p = speed >> lvl;
        return (p == 4'd0) ? 4'd1 : p;
    endfunction

    function automatic logic [5:0] next_x(input logic [5:0] x, input logic right);
        if (right)
            return (x == X_LAST) ? 6'd0 : x + 6'd1;
        else
            return (x == 6'd0) ? X_LAST : x - 6'd1;
    endfunction

    assign tick = i_Enable && (presc == PRESC_LAST);

    // ">=" rather than "==" so a counter stranded above a freshly shortened period still fires.
    always_comb begin
        move = '0;
        for (int unsigned n = 0; n < N_CARS; n++) begin
            move[n] = tick && !i_Freeze && (lane_cnt[n] >= eff_period(SPEED[n], level) - 4'd1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            presc <= '0;
            level <= '0;
            step  <= 1'b0;
        end else begin
            if (i_Enable)
                presc <= tick ? '0 : presc + 1'b1;
            if (i_Level_Reset)
                level <= '0;
            else if (i_Speed_Up && level != 2'd3)
                level <= level + 2'd1;
            step <= |move;
        end
    end

    always_ff @(posedge i_Clk) begin
        for (int unsigned n = 0; n < N_CARS; n++) begin
            car_y[n] <= LANE_Y[n];
            if (i_Reset) begin
                car_x[n]    <= START_X[n];
                lane_cnt[n] <= '0;
            end else if (move[n]) begin
                car_x[n]    <= next_x(car_x[n], c_DIR[n]);
                lane_cnt[n] <= '0;
            end else if (tick && !i_Freeze) begin
                lane_cnt[n] <= lane_cnt[n] + 4'd1;
            end
        end
    end

    assign o_Car_X_1 = car_x[0];
    assign o_Car_X_2 = car_x[1];
    assign o_Car_X_3 = car_x[2];
    assign o_Car_X_4 = car_x[3];
    assign o_Car_X_5 = car_x[4];
    assign o_Car_Y_1 = car_y[0];
    assign o_Car_Y_2 = car_y[1];
    assign o_Car_Y_3 = car_y[2];
    assign o_Car_Y_4 = car_y[3];
    assign o_Car_Y_5 = car_y[4];
    assign o_Level   = level;
    assign o_Step    = step;

endmodule

// File: tb/tb_frogger_car_traffic.sv
// Bench for frogger_car_traffic: per-cycle comparison against a tick-counting
// model plus hand-computed checkpoints on a short prescaler.
`timescale 1ns/1ps
module tb_frogger_car_traffic;

    localparam int W   = 14;
    localparam int DIV = 4;
    localparam int START [5] = '{12, 0, 6, 9, 13};
    localparam int SPD   [5] = '{1, 1, 4, 3, 5};
    localparam int RIGHT [5] = '{1, 0, 1, 0, 1};
    localparam int LANEY [5] = '{9, 8, 7, 6, 5};

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, frz = 1'b0, su = 1'b0, lr = 1'b0;
    logic [5:0] x1, x2, x3, x4, x5, y1, y2, y3, y4, y5;
    logic [1:0] lvl;
    logic step;
    logic [5:0] dut_x [5];
    logic [5:0] dut_y [5];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    frogger_car_traffic #(
        .c_GAME_WIDTH(14), .c_BASE_DIV(4),
        .c_START_X_1(6'd12), .c_START_X_2(6'd0), .c_START_X_3(6'd6), .c_START_X_4(6'd9), .c_START_X_5(6'd13),
        .c_SPEED_1(4'd1), .c_SPEED_2(4'd1), .c_SPEED_3(4'd4), .c_SPEED_4(4'd3), .c_SPEED_5(4'd5),
        .c_DIR(5'b10101)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Freeze(frz),
        .i_Speed_Up(su), .i_Level_Reset(lr),
        .o_Car_X_1(x1), .o_Car_X_2(x2), .o_Car_X_3(x3), .o_Car_X_4(x4), .o_Car_X_5(x5),
        .o_Car_Y_1(y1), .o_Car_Y_2(y2), .o_Car_Y_3(y3), .o_Car_Y_4(y4), .o_Car_Y_5(y5),
        .o_Level(lvl), .o_Step(step)
    );

    assign dut_x = '{x1, x2, x3, x4, x5};
    assign dut_y = '{y1, y2, y3, y4, y5};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts enabled cycles and accepted ticks directly.
    int  m_x [5];
    int  m_acc [5];
    int  m_lvl = 0;
    int  m_en_cycles = 0;
    int  m_p;
    bit  m_tick;
    bit  m_step = 0;
    bit  m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_en_cycles = 0;
            m_lvl = 0;
            m_step = 0;
            for (int n = 0; n < 5; n++) begin
                m_x[n] = START[n];
                m_acc[n] = 0;
            end
        end else begin
            m_tick = en && (m_en_cycles % DIV == DIV - 1);
            if (en) m_en_cycles++;
            m_step = 0;
            if (m_tick && !frz) begin
                for (int n = 0; n < 5; n++) begin
                    m_p = SPD[n] / (1 << m_lvl);
                    if (m_p < 1) m_p = 1;
                    m_acc[n]++;
                    if (m_acc[n] >= m_p) begin
                        m_acc[n] = 0;
                        m_x[n] = (m_x[n] + (RIGHT[n] != 0 ? 1 : W - 1)) % W;
                        m_step = 1;
                    end
                end
            end
            if (lr) m_lvl = 0;
            else if (su && m_lvl < 3) m_lvl++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int n = 0; n < 5; n++) begin
                check($sformatf("model_x%0d", n + 1), int'(dut_x[n]), m_x[n]);
                check($sformatf("y%0d", n + 1), int'(dut_y[n]), LANEY[n]);
            end
            check("model_level", int'(lvl), m_lvl);
            check("model_step", int'(step), int'(m_step));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0; en = 1'b1;
        check("rst_x1", x1, 12); check("rst_x2", x2, 0); check("rst_x5", x5, 13);
        check("rst_y1", y1, 9); check("rst_level", lvl, 0); check("rst_step", step, 0);

        cyc(4);  check("t1_x1", x1, 13); check("t1_x2", x2, 13); check("t1_step", step, 1);
        cyc(1);  check("t1_step_low", step, 0);
        cyc(3);  check("t2_x1_wrap", x1, 0); check("t2_x2", x2, 12);
        cyc(4);  check("t3_x3_hold", x3, 6);
        cyc(4);  check("t4_x3_move", x3, 7);

        su = 1'b1; cyc(2); su = 1'b0;
        cyc(2);
        check("lvl2", lvl, 2); check("t5_x3", x3, 8); check("t5_x5_over", x5, 0); check("t5_x4", x4, 7);
        su = 1'b1; cyc(2); su = 1'b0;
        check("lvl3", lvl, 3);
        su = 1'b1; cyc(1); su = 1'b0;
        check("lvl_sat", lvl, 3);

        frz = 1'b1; cyc(12);
        check("frz_x1", x1, 3); check("frz_x2", x2, 9); check("frz_x3", x3, 8);
        check("frz_x4", x4, 7); check("frz_x5", x5, 0); check("frz_step", step, 0);
        frz = 1'b0; cyc(1);
        check("unfrz_x1", x1, 4); check("unfrz_x2", x2, 8); check("unfrz_x4", x4, 6); check("unfrz_step", step, 1);

        cyc(2);
        en = 1'b0; cyc(10);
        check("dis_x1", x1, 4);
        en = 1'b1; cyc(1);
        check("reen_x1_wait", x1, 4);
        cyc(1);
        check("reen_x1_tick", x1, 5); check("reen_x2", x2, 7);

        rst = 1'b1; su = 1'b1; cyc(1);
        check("mid_rst_x1", x1, 12); check("mid_rst_x4", x4, 9); check("mid_rst_level", lvl, 0); check("mid_rst_step", step, 0);
        rst = 1'b0; cyc(1);
        check("post_rst_lvl1", lvl, 1);
        lr = 1'b1; cyc(1); lr = 1'b0; su = 1'b0;
        check("both_pulse_lvl", lvl, 0);
        cyc(1); check("restart_x1_hold", x1, 12);
        cyc(1); check("restart_x1_tick", x1, 13);

        for (int i = 0; i < 90; i++) begin
            en  = (i % 7 != 3);
            frz = (i % 11 == 5) || (i % 11 == 6);
            su  = (i % 13 == 2);
            lr  = (i % 37 == 30);
            cyc(1);
        end
        en = 1'b1; frz = 1'b0; su = 1'b0; lr = 1'b0;
        cyc(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog run did not finish");
        $fatal(1);
    end

endmodule
